// File: rtl/pyrm_wb_arbiter_if.sv
// Writeback bus for pyrm_wb_arbiter: ALU and load requesters on one side,
// register-file write port and x0 drop counter on the other.
interface pyrm_wb_arbiter_if;
    logic [4:0]  alu_addr_pyri;
    logic [63:0] alu_data_pyri;
    logic        alu_valid_pyri;
    logic        alu_retry_pyro;
    logic [4:0]  mem_addr_pyri;
    logic [63:0] mem_data_pyri;
    logic        mem_valid_pyri;
    logic        mem_retry_pyro;
    logic [63:0] reg_addr_pyro;
    logic        reg_addr_valid_pyro;
    logic        reg_addr_retry_pyri;
    logic [63:0] reg_data_pyro;
    logic        reg_data_valid_pyro;
    logic        reg_data_retry_pyri;
    logic [15:0] drop_cnt_pyro;

    modport master (
        output alu_addr_pyri, alu_data_pyri, alu_valid_pyri,
        input  alu_retry_pyro,
        output mem_addr_pyri, mem_data_pyri, mem_valid_pyri,
        input  mem_retry_pyro,
        input  reg_addr_pyro, reg_addr_valid_pyro,
        output reg_addr_retry_pyri,
        input  reg_data_pyro, reg_data_valid_pyro,
        output reg_data_retry_pyri,
        input  drop_cnt_pyro
    );

    modport slave (
        input  alu_addr_pyri, alu_data_pyri, alu_valid_pyri,
        output alu_retry_pyro,
        input  mem_addr_pyri, mem_data_pyri, mem_valid_pyri,
        output mem_retry_pyro,
        output reg_addr_pyro, reg_addr_valid_pyro,
        input  reg_addr_retry_pyri,
        output reg_data_pyro, reg_data_valid_pyro,
        input  reg_data_retry_pyri,
        output drop_cnt_pyro
    );
endinterface

// File: rtl/pyrm_wb_arbiter.sv
// Two-requester writeback arbiter with a single output slot and x0 drop counter.
// Define PYRM_WB_RR_EN for round-robin; default is fixed priority (MEM wins).
module pyrm_wb_arbiter (
    input  logic clk,
    input  logic reset_pyri,
    pyrm_wb_arbiter_if.slave bus
);

    logic        slot_v;
    logic [4:0]  slot_a;
    logic [63:0] slot_d;
    logic [15:0] drop_cnt;

    logic alu_x0;
    logic mem_x0;
    logic alu_el;
    logic mem_el;
    logic drain;
    logic slot_free;
    logic grant_alu;
    logic grant_mem;
    logic [1:0] drop_inc;

    assign alu_x0 = bus.alu_valid_pyri & (bus.alu_addr_pyri == 5'd0);
    assign mem_x0 = bus.mem_valid_pyri & (bus.mem_addr_pyri == 5'd0);
    assign alu_el = bus.alu_valid_pyri & (bus.alu_addr_pyri != 5'd0);
    assign mem_el = bus.mem_valid_pyri & (bus.mem_addr_pyri != 5'd0);

    assign drain = slot_v
                 & ~(bus.reg_addr_retry_pyri | bus.reg_data_retry_pyri);
    assign slot_free = ~slot_v | drain;

`ifdef PYRM_WB_RR_EN
    // Set when ALU won the last eligible grant; MEM gets the next tie.
    logic alu_last;

    assign grant_mem = slot_free & mem_el & (~alu_el | alu_last);
    assign grant_alu = slot_free & alu_el & (~mem_el | ~alu_last);

    always_ff @(posedge clk) begin
        if (reset_pyri) begin
            alu_last <= 1'b1;
        end else if (grant_alu) begin
            alu_last <= 1'b1;
        end else if (grant_mem) begin
            alu_last <= 1'b0;
        end
    end
`else
    assign grant_mem = slot_free & mem_el;
    assign grant_alu = slot_free & alu_el & ~mem_el;
`endif

    // In reset nothing is accepted, x0 writes included.
    always_comb begin
        if (reset_pyri) begin
            bus.alu_retry_pyro = bus.alu_valid_pyri;
            bus.mem_retry_pyro = bus.mem_valid_pyri;
        end else begin
            bus.alu_retry_pyro = bus.alu_valid_pyri & ~alu_x0 & ~grant_alu;
            bus.mem_retry_pyro = bus.mem_valid_pyri & ~mem_x0 & ~grant_mem;
        end
    end

    assign drop_inc = {1'b0, alu_x0} + {1'b0, mem_x0};

    always_ff @(posedge clk) begin
        if (reset_pyri) begin
            slot_v   <= 1'b0;
            slot_a   <= 5'd0;
            slot_d   <= 64'd0;
            drop_cnt <= 16'd0;
        end else begin
            if (grant_mem) begin
                slot_v <= 1'b1;
                slot_a <= bus.mem_addr_pyri;
                slot_d <= bus.mem_data_pyri;
            end else if (grant_alu) begin
                slot_v <= 1'b1;
                slot_a <= bus.alu_addr_pyri;
                slot_d <= bus.alu_data_pyri;
            end else if (drain) begin
                slot_v <= 1'b0;
            end
            drop_cnt <= drop_cnt + {14'd0, drop_inc};
        end
    end

    assign bus.reg_addr_pyro       = {59'd0, slot_a};
    assign bus.reg_addr_valid_pyro = slot_v;
    assign bus.reg_data_pyro       = slot_d;
    assign bus.reg_data_valid_pyro = slot_v;
    assign bus.drop_cnt_pyro       = drop_cnt;

endmodule
